bsg_packed_cmd_arbiter: RTL and testbench
=========================================

BSG_PACKED_CMD_ARBITER -- requirements
Module: bsg_packed_cmd_arbiter

Interface
REQ-001 Parameter num_req_p, default 2, SHALL set the number of requesters (range 2..8).
REQ-002 Parameter timeout_p, default 1024, SHALL set the read-response timeout in cycles (range 2..65535).
REQ-003 Parameter err_data_p, default 32'hDEAD_BEEF, SHALL set the data word returned on read timeout.
REQ-004 One clock; reset is asynchronous and active-low; ports are clk_i (input, 1, clock) and aresetn_i (input, 1, async active-low reset).
REQ-005 req_data_i, input, num_req_p x 32: packed command per requester ({write_not_read, addr[22:0], data[7:0]}).
REQ-006 req_v_i / req_ready_o, input / output, num_req_p each: command valid/ready per requester.
REQ-007 rsp_data_o, output, 32: read response data, shared by all requesters.
REQ-008 rsp_v_o / rsp_ready_i, output / input, num_req_p each: response valid/ready per requester.
REQ-009 cmd_data_o / cmd_v_o / cmd_ready_i, output 32 / output 1 / input 1: downstream packed-command channel.
REQ-010 cmd_data_i / cmd_v_i / cmd_ready_o, input 32 / input 1 / output 1: downstream read-response channel.
REQ-011 timeout_o, output, 1: sticky flag, set on any read timeout or discarded stray response.

Function
REQ-012 Exactly one transaction SHALL be outstanding at a time.
REQ-013 The FSM SHALL have states e_idle, e_send, e_wait, e_err.
REQ-014 e_idle: round-robin grant among asserted req_v_i, starting at last-granted index +1 (wrap at num_req_p-1 -> 0); req_ready_o asserted only for the granted index, in the same cycle; command and grant index latched; next state e_send.
REQ-015 After reset, the round-robin pointer SHALL favour index 0 first.
REQ-016 e_send: cmd_v_o=1 with the latched command; cmd_data_o SHALL be stable until cmd_ready_i; on handshake, bit 31=1 -> e_idle, bit 31=0 -> e_wait with the timeout counter cleared.
REQ-017 Command latency SHALL be exactly 1 cycle from req handshake to the first cycle of cmd_v_o.
REQ-018 e_wait: rsp_v_o[grant]=cmd_v_i, rsp_data_o=cmd_data_i, cmd_ready_o=rsp_ready_i[grant] (combinational pass-through); on handshake -> e_idle.
REQ-019 e_wait: the counter SHALL increment each cycle without cmd_v_i; at count == timeout_p-1 -> e_err, timeout_o set.
REQ-020 e_err: rsp_v_o[grant]=1, rsp_data_o=err_data_p, cmd_ready_o=0; on rsp_ready_i[grant] -> e_idle.
REQ-021 e_idle: cmd_ready_o=1; any cmd_v_i SHALL be discarded and timeout_o set.
REQ-022 rsp_v_o bits other than grant SHALL be 0; at most one req_ready_o bit SHALL be high per cycle.
REQ-023 In e_idle with no req_v_i asserted, the FSM and pointer SHALL hold.
REQ-024 The counter SHALL saturate and not wrap; its width SHALL be clog2(timeout_p)+1.

Reset
REQ-025 aresetn_i low SHALL immediately force e_idle, pointer=0, counter=0, timeout_o=0, cmd_v_o=0, all rsp_v_o=0; when in e_idle, req_ready_o depends only on req_v_i.
REQ-026 Reset mid-transaction SHALL abandon it with no response; the next response arriving in e_idle is discarded per REQ-021.

Structure
REQ-027 The state enum and packed-command struct (write bit 31, addr 30:8, data 7:0) SHALL live in a shared package usable by the store packer.
REQ-028 Arbitration SHALL use one sub-module, bsg_arb_round_robin; everything else stays flat.

Verification
REQ-029 Write from req 1 with data 32'h8000_1255: cmd_data_o=32'h8000_1255 one cycle later; no rsp_v_o; back to e_idle.
REQ-030 Read from req 0 (32'h0000_4400); downstream returns 32'h0000_00AB after 5 cycles: rsp_v_o=2'b01, rsp_data_o=32'h0000_00AB.
REQ-031 Both requesters assert reads continuously for 4 transactions: grants alternate 0,1,0,1.
REQ-032 Read with no response and timeout_p=16: rsp_data_o=32'hDEAD_BEEF after 16 wait cycles; timeout_o=1; a late cmd_v_i is discarded in e_idle.
REQ-033 cmd_ready_i held low for 10 cycles in e_send: cmd_data_o stable throughout; single handshake.
REQ-034 aresetn_i low during e_wait: all outputs at reset values within the same cycle; timeout_o=0.

Source files
------------

// File: rtl/bsg_packed_cmd_arbiter_pkg.sv
// Shared types for the packed-command arbiter and the store packer.
// Command layout: {write_not_read, addr[22:0], data[7:0]}.
package bsg_packed_cmd_arbiter_pkg;

    localparam int cmd_width_lp = 32;

    typedef enum logic [1:0] {
        e_idle,
        e_send,
        e_wait,
        e_err
    } arb_state_e;

    typedef struct packed {
        logic        write_not_read;
        logic [22:0] addr;
        logic [7:0]  data;
    } packed_cmd_s;

    function automatic logic cmd_is_write(packed_cmd_s cmd);
        return cmd.write_not_read;
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter. The search starts at the index after the last grant;
// the pointer only advances when the caller accepts the grant.
module bsg_arb_round_robin #(
    parameter  int num_req_p = 2,
    localparam int idx_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                 clk_i,
    input  logic                 aresetn_i,
    input  logic [num_req_p-1:0] reqs_i,
    input  logic                 yumi_i,
    output logic [num_req_p-1:0] grants_o,
    output logic [idx_w_lp-1:0]  grant_idx_o,
    output logic                 v_o
);

    logic [idx_w_lp-1:0] ptr_r;
    logic [idx_w_lp-1:0] cand;

    always_comb begin
        grants_o    = '0;
        grant_idx_o = '0;
        v_o         = 1'b0;
        cand        = '0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = idx_w_lp'((int'(ptr_r) + i) % num_req_p);
            if (!v_o && reqs_i[cand]) begin
                v_o            = 1'b1;
                grant_idx_o    = cand;
                grants_o[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            ptr_r <= '0;
        end else if (yumi_i && v_o) begin
            ptr_r <= (grant_idx_o == idx_w_lp'(num_req_p - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/bsg_packed_cmd_arbiter.sv
// Arbitrates packed commands from several requesters onto one downstream
// channel, one transaction in flight, with a read-response timeout.
//   state  | meaning
//   e_idle | waiting for a request; stray downstream responses are dropped
//   e_send | presenting the latched command downstream
//   e_wait | passing the read response through to the granted requester
//   e_err  | returning err_data_p after a read timeout
module bsg_packed_cmd_arbiter
    import bsg_packed_cmd_arbiter_pkg::*;
#(
    parameter int          num_req_p  = 2,
    parameter int          timeout_p  = 1024,
    parameter logic [31:0] err_data_p = 32'hDEAD_BEEF
) (
    input  logic                       clk_i,
    input  logic                       aresetn_i,
    input  logic [num_req_p-1:0][31:0] req_data_i,
    input  logic [num_req_p-1:0]       req_v_i,
    output logic [num_req_p-1:0]       req_ready_o,
    output logic [31:0]                rsp_data_o,
    output logic [num_req_p-1:0]       rsp_v_o,
    input  logic [num_req_p-1:0]       rsp_ready_i,
    output logic [31:0]                cmd_data_o,
    output logic                       cmd_v_o,
    input  logic                       cmd_ready_i,
    input  logic [31:0]                cmd_data_i,
    input  logic                       cmd_v_i,
    output logic                       cmd_ready_o,
    output logic                       timeout_o
);

    localparam int idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_w_lp = $clog2(timeout_p) + 1;
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(timeout_p - 1);

    arb_state_e            state_r, state_n;
    logic [idx_w_lp-1:0]   grant_r;
    packed_cmd_s           cmd_r;
    logic [cnt_w_lp-1:0]   cnt_r;
    logic                  timeout_r;
    logic                  set_timeout;

    logic [num_req_p-1:0]  arb_grants;
    logic [idx_w_lp-1:0]   arb_idx;
    logic                  arb_v;
    logic                  in_idle;

    assign in_idle = (state_r == e_idle);

    bsg_arb_round_robin #(
        .num_req_p (num_req_p)
    ) u_arb (
        .clk_i       (clk_i),
        .aresetn_i   (aresetn_i),
        .reqs_i      (req_v_i),
        .yumi_i      (in_idle),
        .grants_o    (arb_grants),
        .grant_idx_o (arb_idx),
        .v_o         (arb_v)
    );

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_r   <= e_idle;
            grant_r   <= '0;
            cmd_r     <= '0;
            cnt_r     <= '0;
            timeout_r <= 1'b0;
        end else begin
            state_r <= state_n;
            if (in_idle && arb_v) begin
                grant_r <= arb_idx;
                cmd_r   <= req_data_i[arb_idx];
            end
            // Cleared while sending so a fresh read wait always starts at zero.
            if (state_r == e_send) begin
                cnt_r <= '0;
            end else if (state_r == e_wait && !cmd_v_i && cnt_r != '1) begin
                cnt_r <= cnt_r + 1'b1;
            end
            if (set_timeout) begin
                timeout_r <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state_r;
        req_ready_o = '0;
        cmd_v_o     = 1'b0;
        cmd_data_o  = cmd_r;
        rsp_v_o     = '0;
        rsp_data_o  = '0;
        cmd_ready_o = 1'b0;
        set_timeout = 1'b0;

        case (state_r)
            e_idle: begin
                req_ready_o = arb_grants;
                cmd_ready_o = 1'b1;
                set_timeout = cmd_v_i;
                if (arb_v) begin
                    state_n = e_send;
                end
            end
            e_send: begin
                cmd_v_o = 1'b1;
                if (cmd_ready_i) begin
                    state_n = cmd_is_write(cmd_r) ? e_idle : e_wait;
                end
            end
            e_wait: begin
                rsp_v_o[grant_r] = cmd_v_i;
                rsp_data_o       = cmd_data_i;
                cmd_ready_o      = rsp_ready_i[grant_r];
                if (cmd_v_i && rsp_ready_i[grant_r]) begin
                    state_n = e_idle;
                end else if (!cmd_v_i && cnt_r == cnt_last_lp) begin
                    state_n     = e_err;
                    set_timeout = 1'b1;
                end
            end
            e_err: begin
                rsp_v_o[grant_r] = 1'b1;
                rsp_data_o       = err_data_p;
                if (rsp_ready_i[grant_r]) begin
                    state_n = e_idle;
                end
            end
            default: begin
                state_n = e_idle;
            end
        endcase
    end

    assign timeout_o = timeout_r;

endmodule

// File: tb/tb_bsg_packed_cmd_arbiter.sv
// Bench for bsg_packed_cmd_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_bsg_packed_cmd_arbiter;

    localparam int          N   = 2;
    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic                clk_i = 1'b0;
    logic                aresetn_i = 1'b1;
    logic [N-1:0][31:0]  req_data_i = '0;
    logic [N-1:0]        req_v_i = '0;
    logic [N-1:0]        req_ready_o;
    logic [31:0]         rsp_data_o;
    logic [N-1:0]        rsp_v_o;
    logic [N-1:0]        rsp_ready_i = '0;
    logic [31:0]         cmd_data_o;
    logic                cmd_v_o;
    logic                cmd_ready_i = 1'b0;
    logic [31:0]         cmd_data_i = '0;
    logic                cmd_v_i = 1'b0;
    logic                cmd_ready_o;
    logic                timeout_o;

    bsg_packed_cmd_arbiter #(
        .num_req_p  (N),
        .timeout_p  (TO),
        .err_data_p (ERR)
    ) dut (
        .clk_i       (clk_i),
        .aresetn_i   (aresetn_i),
        .req_data_i  (req_data_i),
        .req_v_i     (req_v_i),
        .req_ready_o (req_ready_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_v_o     (rsp_v_o),
        .rsp_ready_i (rsp_ready_i),
        .cmd_data_o  (cmd_data_o),
        .cmd_v_o     (cmd_v_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_v_i     (cmd_v_i),
        .cmd_ready_o (cmd_ready_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: who owns the channel and how far it got.
    int          m_ptr = 0;
    bit          m_active = 0;
    int          m_grant = 0;
    logic [31:0] m_cmd = '0;
    bit          m_sent = 0;
    int          m_miss = 0;
    bit          m_flag = 0;
    int          grant_log[$];
    int          cmd_hs_count = 0;
    logic [N-1:0] last_hs = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_cycle();
        int           pick;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rsp;
        exp_rdy = '0;
        exp_rsp = '0;
        last_hs = req_v_i & req_ready_o;
        if (cmd_v_o && cmd_ready_i) cmd_hs_count++;
        check_eq("timeout_o", timeout_o, m_flag);
        if (!m_active) begin
            pick = rr_pick(req_v_i, m_ptr);
            if (pick >= 0) exp_rdy[pick] = 1'b1;
            check_eq("idle_req_ready", req_ready_o, exp_rdy);
            check_eq("idle_cmd_v", cmd_v_o, 0);
            check_eq("idle_rsp_v", rsp_v_o, 0);
            check_eq("idle_cmd_ready", cmd_ready_o, 1);
            if (cmd_v_i) m_flag = 1;
            if (pick >= 0) begin
                m_active = 1;
                m_grant  = pick;
                m_cmd    = req_data_i[pick];
                m_sent   = 0;
                m_ptr    = (pick + 1) % N;
                grant_log.push_back(pick);
            end
        end else if (!m_sent) begin
            check_eq("send_req_ready", req_ready_o, 0);
            check_eq("send_cmd_v", cmd_v_o, 1);
            check_eq("send_cmd_data", cmd_data_o, m_cmd);
            check_eq("send_rsp_v", rsp_v_o, 0);
            if (cmd_ready_i) begin
                if (m_cmd[31]) m_active = 0;
                else begin
                    m_sent = 1;
                    m_miss = 0;
                end
            end
        end else if (m_miss < TO) begin
            exp_rsp[m_grant] = cmd_v_i;
            check_eq("wait_req_ready", req_ready_o, 0);
            check_eq("wait_cmd_v", cmd_v_o, 0);
            check_eq("wait_rsp_v", rsp_v_o, exp_rsp);
            check_eq("wait_cmd_ready", cmd_ready_o, rsp_ready_i[m_grant]);
            if (cmd_v_i) check_eq("wait_rsp_data", rsp_data_o, cmd_data_i);
            if (cmd_v_i && rsp_ready_i[m_grant]) m_active = 0;
            else if (!cmd_v_i) begin
                m_miss++;
                if (m_miss == TO) m_flag = 1;
            end
        end else begin
            exp_rsp[m_grant] = 1'b1;
            check_eq("err_req_ready", req_ready_o, 0);
            check_eq("err_rsp_v", rsp_v_o, exp_rsp);
            check_eq("err_rsp_data", rsp_data_o, ERR);
            check_eq("err_cmd_ready", cmd_ready_o, 0);
            if (rsp_ready_i[m_grant]) m_active = 0;
        end
    endtask

    // Inputs are set at the falling edge; outputs are judged 1 time unit later.
    task automatic cycle();
        #1;
        model_cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic reset_now();
        logic [N-1:0] exp_rdy;
        int           pick;
        aresetn_i = 1'b0;
        #1;
        exp_rdy = '0;
        pick = rr_pick(req_v_i, 0);
        if (pick >= 0) exp_rdy[pick] = 1'b1;
        check_eq("rst_cmd_v", cmd_v_o, 0);
        check_eq("rst_rsp_v", rsp_v_o, 0);
        check_eq("rst_timeout", timeout_o, 0);
        check_eq("rst_cmd_ready", cmd_ready_o, 1);
        check_eq("rst_req_ready", req_ready_o, exp_rdy);
        m_active = 0;
        m_ptr    = 0;
        m_flag   = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        aresetn_i = 1'b1;
    endtask

    task automatic drain();
        req_v_i     = '0;
        cmd_ready_i = 1'b1;
        rsp_ready_i = '1;
        for (int k = 0; k < 60 && m_active; k++) begin
            cmd_v_i    = m_sent && (m_miss < TO);
            cmd_data_i = $urandom;
            cycle();
        end
        check_eq("drain_done", m_active, 0);
        cmd_v_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int waits;
        int hs_before;
        bit silent;

        #2;
        req_v_i = 2'b11;
        reset_now();
        req_v_i = '0;

        // Write from requester 1, one-cycle command latency.
        req_v_i       = 2'b10;
        req_data_i[1] = 32'h8000_1255;
        cmd_ready_i   = 1'b1;
        cycle();
        req_v_i = '0;
        #1;
        check_eq("wr_cmd_v_next", cmd_v_o, 1);
        check_eq("wr_cmd_data_next", cmd_data_o, 32'h8000_1255);
        cycle();
        cycle();
        check_eq("wr_no_rsp", rsp_v_o, 0);

        // Read from requester 0, response five cycles later.
        req_v_i       = 2'b01;
        req_data_i[0] = 32'h0000_4400;
        rsp_ready_i   = 2'b11;
        cycle();
        req_v_i = '0;
        cycle();
        for (int k = 0; k < 5; k++) cycle();
        cmd_v_i    = 1'b1;
        cmd_data_i = 32'h0000_00AB;
        #1;
        check_eq("rd_rsp_v", rsp_v_o, 2'b01);
        check_eq("rd_rsp_data", rsp_data_o, 32'h0000_00AB);
        cycle();
        cmd_v_i = 1'b0;
        drain();

        // Both requesters reading continuously alternate grants.
        reset_now();
        req_data_i[0] = 32'h0000_1100;
        req_data_i[1] = 32'h0000_2200;
        req_v_i       = 2'b11;
        cmd_ready_i   = 1'b1;
        rsp_ready_i   = 2'b11;
        base = grant_log.size();
        for (int k = 0; k < 60 && grant_log.size() < base + 4; k++) begin
            cmd_v_i    = m_active && m_sent && (m_miss < TO);
            cmd_data_i = $urandom;
            cycle();
        end
        check_eq("rr_count", grant_log.size() - base, 4);
        for (int k = 0; k < 4; k++) begin
            if (grant_log.size() > base + k) check_eq("rr_grant", grant_log[base + k], k % 2);
        end
        drain();

        // Downstream stalls the command for ten cycles.
        cmd_ready_i   = 1'b0;
        req_v_i       = 2'b01;
        req_data_i[0] = 32'h8012_3456;
        cycle();
        req_v_i   = '0;
        hs_before = cmd_hs_count;
        for (int k = 0; k < 10; k++) cycle();
        cmd_ready_i = 1'b1;
        cycle();
        cycle();
        check_eq("stall_single_hs", cmd_hs_count - hs_before, 1);
        drain();

        // Read with no response times out after TO wait cycles.
        rsp_ready_i   = '0;
        req_v_i       = 2'b01;
        req_data_i[0] = 32'h0000_7700;
        cycle();
        req_v_i = '0;
        cycle();
        waits = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (rsp_v_o != 0) break;
            cycle();
            waits++;
        end
        check_eq("to_wait_cycles", waits, TO);
        check_eq("to_rsp_data", rsp_data_o, ERR);
        check_eq("to_flag", timeout_o, 1);
        rsp_ready_i = 2'b01;
        cycle();
        cmd_v_i    = 1'b1;
        cmd_data_i = 32'h1234_5678;
        #1;
        check_eq("late_rsp_dropped", rsp_v_o, 0);
        cycle();
        cmd_v_i = 1'b0;
        drain();

        // Reset while a read response is being presented.
        rsp_ready_i   = '0;
        req_v_i       = 2'b10;
        req_data_i[1] = 32'h0000_0900;
        cycle();
        req_v_i = '0;
        cycle();
        cycle();
        cycle();
        cmd_v_i    = 1'b1;
        cmd_data_i = 32'h0000_0055;
        cycle();
        reset_now();
        cycle();
        cmd_v_i = 1'b0;
        cycle();
        check_eq("post_rst_flag", timeout_o, 1);
        drain();

        // Random traffic.
        silent = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_v_i[i] && last_hs[i]) req_v_i[i] = 1'b0;
                if (!req_v_i[i] && ($urandom % 3 == 0)) begin
                    req_v_i[i]    = 1'b1;
                    req_data_i[i] = $urandom;
                end
            end
            if ($urandom % 60 == 0) silent = ~silent;
            cmd_ready_i = ($urandom % 3 != 0);
            rsp_ready_i = N'($urandom);
            cmd_v_i     = !silent && ($urandom % 3 == 0);
            cmd_data_i  = $urandom;
            cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
